// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a shared single-port RAM, 2-stage pipeline.
// Optional burst lock: define MEM_ARB_BURST_LOCK_EN.
module mem_port_arbiter #(
  parameter int async_reset = 0,
  parameter int abits = 18,
  parameter int dbits = 64
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_m0_valid,
  input  logic [abits-1:0]   i_m0_addr,
  input  logic               i_m0_write,
  input  logic [dbits-1:0]   i_m0_wdata,
  input  logic [dbits/8-1:0] i_m0_wstrb,
  input  logic               i_m0_last,
  output logic               o_m0_ready,
  output logic               o_m0_resp_valid,
  output logic [dbits-1:0]   o_m0_rdata,
  input  logic               i_m1_valid,
  input  logic [abits-1:0]   i_m1_addr,
  input  logic               i_m1_write,
  input  logic [dbits-1:0]   i_m1_wdata,
  input  logic [dbits/8-1:0] i_m1_wstrb,
  input  logic               i_m1_last,
  output logic               o_m1_ready,
  output logic               o_m1_resp_valid,
  output logic [dbits-1:0]   o_m1_rdata,
  output logic [abits-1:0]   o_mem_addr,
  output logic               o_mem_we,
  output logic [dbits/8-1:0] o_mem_wstrb,
  output logic [dbits-1:0]   o_mem_wdata,
  input  logic [dbits-1:0]   i_mem_rdata
);

  logic               rr_last;
  logic               g0;
  logic               g1;
  logic               acc;
  logic               acc_id;
  logic [abits-1:0]   sel_addr;
  logic               sel_write;
  logic [dbits-1:0]   sel_wdata;
  logic [dbits/8-1:0] sel_wstrb;
  logic               s1_valid;
  logic               s1_owner;
  logic               s2_valid;
  logic               s2_owner;
  logic               unused_cfg;

  // Reset is asynchronous whatever async_reset says.
  assign unused_cfg = ^{i_m0_last, i_m1_last, 1'(async_reset)};

`ifdef MEM_ARB_BURST_LOCK_EN
  logic       lock_act;
  logic       lock_own;
  logic [3:0] idle_cnt;
  logic       acc_last;
  logic       own_valid;

  assign acc_last  = acc_id ? i_m1_last : i_m0_last;
  assign own_valid = lock_own ? i_m1_valid : i_m0_valid;
`endif

  // rr_last holds the last accepted requester; 1 means m0 preferred.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (i_m0_valid && i_m1_valid) begin
      g0 = rr_last;
      g1 = ~rr_last;
    end else begin
      g0 = i_m0_valid;
      g1 = i_m1_valid;
    end
`ifdef MEM_ARB_BURST_LOCK_EN
    if (lock_act) begin
      g0 = ~lock_own & i_m0_valid;
      g1 = lock_own & i_m1_valid;
    end
`endif
  end

  assign acc    = g0 | g1;
  assign acc_id = g1;

  assign sel_addr  = acc_id ? i_m1_addr  : i_m0_addr;
  assign sel_write = acc_id ? i_m1_write : i_m0_write;
  assign sel_wdata = acc_id ? i_m1_wdata : i_m0_wdata;
  assign sel_wstrb = acc_id ? i_m1_wstrb : i_m0_wstrb;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rr_last <= 1'b1;
    end else if (acc) begin
      rr_last <= acc_id;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s1_valid    <= 1'b0;
      s1_owner    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_wstrb <= '0;
      o_mem_wdata <= '0;
    end else begin
      s1_valid    <= acc;
      s1_owner    <= acc_id;
      o_mem_we    <= acc & sel_write;
      o_mem_wstrb <= (acc && sel_write) ? sel_wstrb : '0;
      if (acc) begin
        o_mem_addr <= sel_addr;
      end
      if (acc && sel_write) begin
        o_mem_wdata <= sel_wdata;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s2_valid <= 1'b0;
      s2_owner <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_owner <= s1_owner;
    end
  end

`ifdef MEM_ARB_BURST_LOCK_EN
  // Lock drops on the owner's last beat or after 15 idle owner cycles.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      lock_act <= 1'b0;
      lock_own <= 1'b0;
      idle_cnt <= 4'd0;
    end else if (acc) begin
      lock_act <= ~acc_last;
      lock_own <= acc_id;
      idle_cnt <= 4'd0;
    end else if (lock_act && !own_valid) begin
      if (idle_cnt == 4'd14) begin
        lock_act <= 1'b0;
        idle_cnt <= 4'd0;
      end else begin
        idle_cnt <= idle_cnt + 4'd1;
      end
    end
  end
`endif

  assign o_m0_ready      = g0;
  assign o_m1_ready      = g1;
  assign o_m0_resp_valid = s2_valid & ~s2_owner;
  assign o_m1_resp_valid = s2_valid & s2_owner;
  assign o_m0_rdata      = i_mem_rdata;
  assign o_m1_rdata      = i_mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter async_reset, default 0: when 1, registers use asynchronous reset; the reset is always asynchronous and active-low in this block regardless of value.
REQ-002 Parameter abits, default 18: word address width of the shared RAM.
REQ-003 Parameter dbits, default 64 (CFG_SYSBUS_DATA_BITS): data width; strobe width is dbits/8.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_nrst  in  1  reset, asynchronous, active-low.
REQ-006 i_mN_valid (N=0,1)  in  1  requester N access request.
REQ-007 i_mN_addr  in  abits  word address.
REQ-008 i_mN_write  in  1  1=write, 0=read.
REQ-009 i_mN_wdata  in  dbits  write data.
REQ-010 i_mN_wstrb  in  dbits/8  byte enables.
REQ-011 i_mN_last  in  1  final beat of a burst.
REQ-012 o_mN_ready  out  1  request accepted this cycle.
REQ-013 o_mN_resp_valid  out  1  response (read data or write ack) for N.
REQ-014 o_mN_rdata  out  dbits  read data, qualified by o_mN_resp_valid.
REQ-015 o_mem_addr  out  abits  registered RAM address.
REQ-016 o_mem_we  out  1  registered RAM write enable.
REQ-017 o_mem_wstrb  out  dbits/8  registered byte enables; zero on reads.
REQ-018 o_mem_wdata  out  dbits  registered write data.
REQ-019 i_mem_rdata  in  dbits  RAM read data, valid one cycle after o_mem_addr.

Function
REQ-020 Accept = i_mN_valid and o_mN_ready in cycle T; at most one requester accepted per cycle; RAM never stalls, so a granted valid is always accepted.
REQ-021 o_mN_ready is combinational from valids, rr pointer and lock state; never asserted for both N.
REQ-022 Arbitration round-robin: one valid wins; both valid -> requester != last-accepted wins; last-accepted pointer updates on every accept.
REQ-023 Pipeline: accept at T -> o_mem_* driven T+1 (stage1) -> o_mN_resp_valid T+2 (stage2) with o_mN_rdata = i_mem_rdata for reads; writes produce a 1-cycle ack with rdata undefined.
REQ-024 Throughput one accept per cycle; back-to-back mixed requesters/reads/writes return responses in acceptance order to the correct owner via registered owner tags.
REQ-025 Stage1 idle cycle: o_mem_we=0, o_mem_wstrb=0; o_mem_addr/o_mem_wdata hold last value.
REQ-026 Write then read to same address on consecutive accepts: read returns the new data (RAM is write-first; arbiter adds no forwarding).
REQ-027 Response valids are single-cycle pulses; no requester backpressure on responses.

Reset
REQ-028 On i_nrst=0 (at any time, including mid-pipeline): rr pointer -> m0 preferred, stage1/stage2 valid=0, lock clear, lock timer=0; o_mem_we=0, o_mem_wstrb=0, o_mem_addr=0, o_mem_wdata=0, o_mN_resp_valid=0; in-flight accesses are discarded without response.
REQ-029 First cycle after reset release: arbitration active; both valid -> m0 wins.

Configuration
REQ-030 Macro MEM_ARB_BURST_LOCK_EN defined: accepting a beat with i_mN_last=0 locks grant to N; other requester gets no ready until N's beat with i_mN_last=1 is accepted.
REQ-031 With lock enabled: 4-bit idle timer counts cycles the lock owner has valid=0; at 15 idle cycles lock releases and the timer clears; timer clears on any owner accept.
REQ-032 Macro undefined: i_mN_last is ignored; pure per-beat round-robin; no lock/timer registers synthesized.

Verification
REQ-033 m0 write addr 0x10 data 0x1122334455667788 wstrb 0xFF at T -> o_mem_we=1 at T+1; m0 read 0x10 -> o_m0_rdata=0x1122334455667788 two cycles after accept.
REQ-034 Both valid continuously, single-beat reads, after reset -> grants m0,m1,m0,m1; responses alternate owners at T+2 each.
REQ-035 Write 0x10 wstrb 0x0F data 0xAAAAAAAAAAAAAAAA over 0x1122334455667788 -> readback 0x11223344AAAAAAAA.
REQ-036 LOCK_EN: m0 4-beat burst (last on beat 4), m1 valid throughout -> m1 ready only after m0 beat 4 accepted; m0 stalls 15 cycles mid-burst -> lock releases, m1 granted.
REQ-037 Assert i_nrst=0 with reads in stage1 and stage2 -> no o_mN_resp_valid after reset; o_mem_we=0; first post-reset contention grants m0.
